clk_en_monitor: RTL and testbench
=================================

# clk_en_monitor

- Checks the core clock-enable pulse train generated from the reference clock.
- Measures the period and high time of each enable cycle and compares them with the values implied by `REF_CLK_FREQ`, `CORE_CLK_FREQ` and `CORE_CLK_DUTY`.
- Raises `locked` after a run of conforming cycles, and reports errors and stalls.
- Sits beside the clock-enable generator in the core clocking path, in the same clock domain.

## Interface
Parameters:
- `REF_CLK_FREQ`, default `core_config_pkg::REF_CLK_FREQ`: reference clock frequency (Hz).
- `CORE_CLK_FREQ`, default `core_config_pkg::CORE_CLK_FREQ`: expected enable rate (Hz).
- `CORE_CLK_DUTY`, default `core_config_pkg::CORE_CLK_DUTY`: expected duty (%).
- `TOL`, default 0: accepted ± deviation, in clk cycles, on both period and high time.
- `LOCK_COUNT`, default 4: consecutive good cycles needed to assert `locked`.

Ports:
- `clk`  in  1  reference clock. One clock only; reset is synchronous and active-high.
- `rst`  in  1  synchronous, active-high reset.
- `clk_en_in`  in  1  monitored enable; synchronous to `clk`, no synchronizer.
- `locked`  out  1  enable train conforms.
- `err`  out  1  one-cycle pulse per detected violation.
- `err_count`  out  8  violation count, saturating at 255.
- `period`  out  W  last measured period, in clk cycles.
- `high_time`  out  W  last measured high time, in clk cycles.

## Operation
Derived constants:
- `EXP_PERIOD = REF_CLK_FREQ / CORE_CLK_FREQ`.
- `EXP_HIGH = ((EXP_PERIOD-1)*CORE_CLK_DUTY)/100 + 1`.
- `TIMEOUT = 2*EXP_PERIOD`.
- `W = $clog2(TIMEOUT+1)`.
- Elaboration error if `EXP_PERIOD < 2` or `EXP_HIGH >= EXP_PERIOD`, because the train would have no edges.

Edge detection and counters:
- `prev` holds the registered `clk_en_in`; it resets to 1.
- A rising edge is `clk_en_in & ~prev`. A line already high at reset release is not an edge.
- `per_cnt` loads 1 on a rising edge, otherwise increments, saturating at `TIMEOUT`.
- `high_cnt` loads 1 on a rising edge, otherwise increments on cycles where `clk_en_in` is 1, saturating at `TIMEOUT`.
- A sample is good when |per_cnt − EXP_PERIOD| ≤ TOL and |high_cnt − EXP_HIGH| ≤ TOL. The comparison uses the counter values held before the edge reload.

FSM states: IDLE, MEASURE, LOCKED.
- **IDLE:** on a rising edge, go to MEASURE with `good_cnt`=0. No comparison is made on this edge.
- **MEASURE, rising edge, good:** `good_cnt`+1. When it reaches `LOCK_COUNT`, go to LOCKED.
- **MEASURE, rising edge, bad:** pulse `err`, clear `good_cnt`, stay in MEASURE.
- **LOCKED, rising edge, good:** stay in LOCKED.
- **LOCKED, rising edge, bad:** pulse `err`, clear `good_cnt`, go to MEASURE.
- **MEASURE or LOCKED, no edge and `per_cnt` == `TIMEOUT`:** covers stuck low and stuck high. Pulse `err`, go to IDLE. Fires once, because IDLE does not re-arm the timeout.
- An edge arriving in the same cycle `per_cnt` hits `TIMEOUT` is judged as a bad sample. The timeout does not fire.
- On every edge in MEASURE or LOCKED, `period` and `high_time` are updated with the measured values.
- `err_count` increments on every `err` pulse and saturates at 255.

Reset values (all outputs): `locked`=0, `err`=0, `err_count`=0, `period`=0, `high_time`=0. State is IDLE, and both counters are 0.

## Timing
- All outputs are registered.
- `period`, `high_time` and `err` update in the cycle after the edge is sampled: 1-cycle latency.
- `locked` changes in the same cycle as the update of the deciding sample.
- Timeout `err` appears 1 cycle after `per_cnt` reaches `TIMEOUT`.
- Reset mid-operation: outputs take their reset values in the cycle after `rst` is sampled high. Nothing carries over.

## Structure
- In `core_config_pkg`:
  - a `clk_mon_state_t` enum (IDLE/MEASURE/LOCKED);
  - a shared function computing `EXP_HIGH`, also used by the clock-enable generator so the two cannot drift.
- One sub-module, `edge_period_counter`, containing `prev`, the edge detect, `per_cnt` and `high_cnt` with saturation. The top module holds the FSM, comparison and output registers.

## Test plan
Base configuration: REF=100 MHz, CORE=25 MHz, DUTY=50 (`EXP_PERIOD`=4, `EXP_HIGH`=2), TOL=0, LOCK_COUNT=4.
- **Nominal train:** pattern 1100 repeated → `locked`=1 one cycle after the 5th rising edge; `period`=4, `high_time`=2; `err` never asserted.
- **Long period while locked:** one 11000 cycle (period 5) → `err` pulses once, `locked`=0, `err_count`=1; relocks after 4 further good edges.
- **Stuck line:** hold `clk_en_in`=0 for 10 cycles after a locked edge → one `err` pulse when `per_cnt`=8, state IDLE. Holding high gives the same result. Only one pulse occurs per stall.
- **Tolerance:** TOL=1 with period-5 cycles (high time 2) → accepted, `locked`=1. A period of 6 → `err`.
- **Reset:** `rst` for 1 cycle while locked and `clk_en_in`=1 → all outputs 0 next cycle; the high level at release is not counted as an edge; relocks after 5 edges.
- **Saturation:** 300 alternating bad periods → `err_count` stops at 255; `period` tracks each sample.

Source files
------------

// File: rtl/core_config_pkg.sv
// Core clocking configuration shared by the clock-enable generator and its monitor.
// Holds the frequency plan, monitor state encoding and the common high-time formula.
package core_config_pkg;

   localparam int REF_CLK_FREQ  = 100_000_000;
   localparam int CORE_CLK_FREQ = 25_000_000;
   localparam int CORE_CLK_DUTY = 50;

   typedef enum logic [1:0] {
      IDLE,
      MEASURE,
      LOCKED
   } clk_mon_state_t;

   // Generator and monitor both call this so their notion of high time cannot diverge.
   function automatic int calc_exp_high(input int exp_period, input int duty_pct);
      return ((exp_period - 1) * duty_pct) / 100 + 1;
   endfunction

endpackage

// File: rtl/edge_period_counter.sv
// Rising-edge detector plus saturating period and high-time counters for the enable line.
// Counters reload to 1 on each rising edge; a line already high out of reset is not an edge.
module edge_period_counter #(
   parameter int TIMEOUT = 8,
   parameter int W       = $clog2(TIMEOUT + 1)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clk_en_in,
   output logic         rise_o,
   output logic [W-1:0] per_cnt_o,
   output logic [W-1:0] high_cnt_o
);

   localparam logic [W-1:0] SAT = W'(TIMEOUT);
   localparam logic [W-1:0] ONE = W'(1);

   logic         prev_q;
   logic [W-1:0] per_cnt_q;
   logic [W-1:0] per_cnt_d;
   logic [W-1:0] high_cnt_q;
   logic [W-1:0] high_cnt_d;

   assign rise_o     = clk_en_in & ~prev_q;
   assign per_cnt_o  = per_cnt_q;
   assign high_cnt_o = high_cnt_q;

   always_comb begin
      per_cnt_d  = per_cnt_q;
      high_cnt_d = high_cnt_q;
      if (rise_o) begin
         per_cnt_d  = ONE;
         high_cnt_d = ONE;
      end else begin
         if (per_cnt_q != SAT) begin
            per_cnt_d = per_cnt_q + ONE;
         end
         if (clk_en_in && (high_cnt_q != SAT)) begin
            high_cnt_d = high_cnt_q + ONE;
         end
      end
   end

   // prev resets high so a level already asserted at release is not taken as an edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q     <= 1'b1;
         per_cnt_q  <= '0;
         high_cnt_q <= '0;
      end else begin
         prev_q     <= clk_en_in;
         per_cnt_q  <= per_cnt_d;
         high_cnt_q <= high_cnt_d;
      end
   end

endmodule

// File: rtl/clk_en_monitor.sv
// Checks period and high time of the core clock-enable train; locks after LOCK_COUNT good cycles.
// All outputs registered, one cycle after the sampled edge; err pulses on bad samples and stalls.
module clk_en_monitor #(
   parameter int REF_CLK_FREQ  = core_config_pkg::REF_CLK_FREQ,
   parameter int CORE_CLK_FREQ = core_config_pkg::CORE_CLK_FREQ,
   parameter int CORE_CLK_DUTY = core_config_pkg::CORE_CLK_DUTY,
   parameter int TOL           = 0,
   parameter int LOCK_COUNT    = 4,
   localparam int EXP_PERIOD   = REF_CLK_FREQ / CORE_CLK_FREQ,
   localparam int TIMEOUT      = 2 * EXP_PERIOD,
   localparam int W            = $clog2(TIMEOUT + 1)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clk_en_in,
   output logic         locked,
   output logic         err,
   output logic [7:0]   err_count,
   output logic [W-1:0] period,
   output logic [W-1:0] high_time
);

   import core_config_pkg::*;

   localparam int EXP_HIGH = calc_exp_high(EXP_PERIOD, CORE_CLK_DUTY);
   localparam int PER_LO   = EXP_PERIOD - TOL;
   localparam int PER_HI   = EXP_PERIOD + TOL;
   localparam int HIGH_LO  = EXP_HIGH - TOL;
   localparam int HIGH_HI  = EXP_HIGH + TOL;
   localparam int GW       = $clog2(LOCK_COUNT + 1);
   localparam logic [GW-1:0] LOCK_CNT = GW'(LOCK_COUNT);

   if ((EXP_PERIOD < 2) || (EXP_HIGH >= EXP_PERIOD)) begin : g_bad_cfg
      $error("clk_en_monitor: configured enable train has no edges");
   end
   if (LOCK_COUNT < 1) begin : g_bad_lock
      $error("clk_en_monitor: LOCK_COUNT must be at least 1");
   end

   logic         rise;
   logic [W-1:0] per_cnt;
   logic [W-1:0] high_cnt;
   logic         good;
   logic         timeout;

   clk_mon_state_t state_q, state_d;
   logic [GW-1:0]  good_cnt_q, good_cnt_d;
   logic           locked_q, locked_d;
   logic           err_q, err_d;
   logic [7:0]     err_count_q, err_count_d;
   logic [W-1:0]   period_q, period_d;
   logic [W-1:0]   high_time_q, high_time_d;

   edge_period_counter #(
      .TIMEOUT (TIMEOUT),
      .W       (W)
   ) u_edge_period_counter (
      .clk        (clk),
      .rst        (rst),
      .clk_en_in  (clk_en_in),
      .rise_o     (rise),
      .per_cnt_o  (per_cnt),
      .high_cnt_o (high_cnt)
   );

   // Counters still hold the finished cycle's values in the edge cycle; reload happens after.
   assign good = (int'(per_cnt) >= PER_LO) && (int'(per_cnt) <= PER_HI) &&
                 (int'(high_cnt) >= HIGH_LO) && (int'(high_cnt) <= HIGH_HI);
   assign timeout = (per_cnt == W'(TIMEOUT));

   always_comb begin
      state_d     = state_q;
      good_cnt_d  = good_cnt_q;
      err_d       = 1'b0;
      period_d    = period_q;
      high_time_d = high_time_q;
      case (state_q)
         IDLE: begin
            if (rise) begin
               state_d    = MEASURE;
               good_cnt_d = '0;
            end
         end
         MEASURE, LOCKED: begin
            if (rise) begin
               period_d    = per_cnt;
               high_time_d = high_cnt;
               if (!good) begin
                  err_d      = 1'b1;
                  good_cnt_d = '0;
                  state_d    = MEASURE;
               end else if (state_q == MEASURE) begin
                  good_cnt_d = good_cnt_q + 1'b1;
                  if (good_cnt_d == LOCK_CNT) begin
                     state_d = LOCKED;
                  end
               end
            end else if (timeout) begin
               // Stall: IDLE does not re-arm, so one pulse per stuck period.
               err_d      = 1'b1;
               good_cnt_d = '0;
               state_d    = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      err_count_d = (err_d && (err_count_q != 8'hFF)) ? err_count_q + 8'd1 : err_count_q;
      locked_d    = (state_d == LOCKED);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         good_cnt_q  <= '0;
         locked_q    <= 1'b0;
         err_q       <= 1'b0;
         err_count_q <= '0;
         period_q    <= '0;
         high_time_q <= '0;
      end else begin
         state_q     <= state_d;
         good_cnt_q  <= good_cnt_d;
         locked_q    <= locked_d;
         err_q       <= err_d;
         err_count_q <= err_count_d;
         period_q    <= period_d;
         high_time_q <= high_time_d;
      end
   end

   assign locked    = locked_q;
   assign err       = err_q;
   assign err_count = err_count_q;
   assign period    = period_q;
   assign high_time = high_time_q;

endmodule

// File: tb/tb_clk_en_monitor.sv
// Bench for clk_en_monitor: instance A uses TOL=0, instance B uses TOL=1, both on one stimulus.
// Stimulus queues hand-computed expectations tagged with the cycle they become visible.
module tb_clk_en_monitor;

   logic clk = 1'b0;
   logic rst;
   logic clk_en_in;

   always #5 clk = ~clk;

   logic       a_locked, a_err, b_locked, b_err;
   logic [7:0] a_err_count, b_err_count;
   logic [3:0] a_period, a_high_time, b_period, b_high_time;

   clk_en_monitor u_dut_a (
      .clk       (clk),
      .rst       (rst),
      .clk_en_in (clk_en_in),
      .locked    (a_locked),
      .err       (a_err),
      .err_count (a_err_count),
      .period    (a_period),
      .high_time (a_high_time)
   );

   clk_en_monitor #(.TOL(1)) u_dut_b (
      .clk       (clk),
      .rst       (rst),
      .clk_en_in (clk_en_in),
      .locked    (b_locked),
      .err       (b_err),
      .err_count (b_err_count),
      .period    (b_period),
      .high_time (b_high_time)
   );

   typedef struct {
      int cyc;
      int dut;
      bit lk;
      bit er;
      int ec;
      int pr;
      int ht;
   } exp_t;

   exp_t  sb_q[$];
   string nm_q[$];
   int    mon_cyc = 0;
   int    total   = 0;
   int    bad     = 0;

   exp_t        mon_e;
   string       mon_nm;
   logic [17:0] got_v, want_v;

   task automatic step(input logic v);
      @(posedge clk);
      #1;
      clk_en_in = v;
   endtask

   // Expectation for the value just driven: visible at the second negedge from now.
   task automatic expect_out(input int dut, input string nm, input bit lk, input bit er,
                             input int ec, input int pr, input int ht);
      exp_t e;
      e.cyc = mon_cyc + 2;
      e.dut = dut;
      e.lk  = lk;
      e.er  = er;
      e.ec  = ec;
      e.pr  = pr;
      e.ht  = ht;
      sb_q.push_back(e);
      nm_q.push_back(nm);
   endtask

   task automatic tail(input int per, input int hi);
      for (int i = 1; i < per; i++) step(i < hi);
   endtask

   task automatic do_reset(input string nm);
      @(posedge clk);
      #1;
      rst       = 1'b1;
      clk_en_in = 1'b0;
      expect_out(0, nm, 0, 0, 0, 0, 0);
      expect_out(1, nm, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      rst       = 1'b0;
      clk_en_in = 1'b0;
   endtask

   initial begin
      forever begin
         @(negedge clk);
         mon_cyc++;
         while (sb_q.size() > 0 && sb_q[0].cyc <= mon_cyc) begin
            mon_e  = sb_q.pop_front();
            mon_nm = nm_q.pop_front();
            if (mon_e.dut == 0) got_v = {a_locked, a_err, a_err_count, a_period, a_high_time};
            else                got_v = {b_locked, b_err, b_err_count, b_period, b_high_time};
            want_v = {mon_e.lk, mon_e.er, mon_e.ec[7:0], mon_e.pr[3:0], mon_e.ht[3:0]};
            total++;
            if (mon_e.cyc != mon_cyc) begin
               bad++;
               $display("FAIL %s dut%0d: check due at cycle %0d reached at %0d",
                        mon_nm, mon_e.dut, mon_e.cyc, mon_cyc);
            end else if (got_v !== want_v) begin
               bad++;
               $display("FAIL %s dut%0d cyc%0d: got lk=%b err=%b cnt=%0d per=%0d hi=%0d, want lk=%b err=%b cnt=%0d per=%0d hi=%0d",
                        mon_nm, mon_e.dut, mon_cyc, got_v[17], got_v[16], got_v[15:8], got_v[7:4], got_v[3:0],
                        want_v[17], want_v[16], want_v[15:8], want_v[7:4], want_v[3:0]);
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b1;
      clk_en_in = 1'b0;
      do_reset("reset");

      // Nominal 1100 train; the 6th cycle is stretched to 11000.
      step(0);
      step(0);
      for (int k = 1; k <= 6; k++) begin
         step(1);
         if (k == 1) begin
            expect_out(0, "nominal_first", 0, 0, 0, 0, 0);
            expect_out(1, "nominal_first", 0, 0, 0, 0, 0);
         end else begin
            expect_out(0, "nominal", k >= 5, 0, 0, 4, 2);
            expect_out(1, "nominal", k >= 5, 0, 0, 4, 2);
         end
         tail((k == 6) ? 5 : 4, 2);
      end

      step(1);
      expect_out(0, "long_period", 0, 1, 1, 5, 2);
      expect_out(1, "long_period_tol", 1, 0, 0, 5, 2);
      tail(4, 2);
      for (int k = 8; k <= 11; k++) begin
         step(1);
         expect_out(0, "relock", k == 11, 0, 1, 4, 2);
         expect_out(1, "relock", 1, 0, 0, 4, 2);
         tail(4, 2);
      end

      // Stuck low after a locked edge.
      step(1);
      expect_out(0, "pre_stall_lo", 1, 0, 1, 4, 2);
      expect_out(1, "pre_stall_lo", 1, 0, 0, 4, 2);
      step(1);
      for (int j = 0; j < 10; j++) begin
         step(0);
         if (j == 6) begin
            expect_out(0, "stall_lo", 0, 1, 2, 4, 2);
            expect_out(1, "stall_lo", 0, 1, 1, 4, 2);
         end else if (j == 7 || j == 9) begin
            expect_out(0, "stall_lo_once", 0, 0, 2, 4, 2);
            expect_out(1, "stall_lo_once", 0, 0, 1, 4, 2);
         end
      end

      for (int k = 1; k <= 5; k++) begin
         step(1);
         if (k == 1 || k == 5) begin
            expect_out(0, "relock2", k == 5, 0, 2, 4, 2);
            expect_out(1, "relock2", k == 5, 0, 1, 4, 2);
         end
         tail(4, 2);
      end

      // Stuck high after a locked edge.
      step(1);
      expect_out(0, "pre_stall_hi", 1, 0, 2, 4, 2);
      expect_out(1, "pre_stall_hi", 1, 0, 1, 4, 2);
      for (int j = 0; j < 10; j++) begin
         step(1);
         if (j == 7) begin
            expect_out(0, "stall_hi", 0, 1, 3, 4, 2);
            expect_out(1, "stall_hi", 0, 1, 2, 4, 2);
         end else if (j >= 8) begin
            expect_out(0, "stall_hi_once", 0, 0, 3, 4, 2);
            expect_out(1, "stall_hi_once", 0, 0, 2, 4, 2);
         end
      end

      // Lock again, then reset for one cycle with the line high.
      step(0);
      step(0);
      for (int k = 1; k <= 5; k++) begin
         step(1);
         if (k == 5) begin
            expect_out(0, "relock3", 1, 0, 3, 4, 2);
            expect_out(1, "relock3", 1, 0, 2, 4, 2);
         end
         tail(4, 2);
      end
      step(1);
      expect_out(0, "locked_before_rst", 1, 0, 3, 4, 2);
      expect_out(1, "locked_before_rst", 1, 0, 2, 4, 2);
      @(posedge clk);
      #1;
      rst       = 1'b1;
      clk_en_in = 1'b1;
      expect_out(0, "rst_hi", 0, 0, 0, 0, 0);
      expect_out(1, "rst_hi", 0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      rst       = 1'b0;
      clk_en_in = 1'b1;
      expect_out(0, "release_hi", 0, 0, 0, 0, 0);
      expect_out(1, "release_hi", 0, 0, 0, 0, 0);
      step(1);
      step(0);
      step(0);
      for (int k = 1; k <= 5; k++) begin
         step(1);
         if (k == 1) begin
            expect_out(0, "post_rst_first", 0, 0, 0, 0, 0);
            expect_out(1, "post_rst_first", 0, 0, 0, 0, 0);
         end else if (k >= 4) begin
            expect_out(0, "post_rst_lock", k == 5, 0, 0, 4, 2);
            expect_out(1, "post_rst_lock", k == 5, 0, 0, 4, 2);
         end
         tail((k <= 5) ? 4 : 4, 2);
      end

      // Tolerance: period 5 accepted only by B, then a period of 6.
      do_reset("reset_tol");
      for (int k = 1; k <= 7; k++) begin
         step(1);
         if (k == 1) begin
            expect_out(0, "tol_first", 0, 0, 0, 0, 0);
            expect_out(1, "tol_first", 0, 0, 0, 0, 0);
         end else if (k <= 6) begin
            expect_out(0, "tol_strict", 0, 1, k - 1, 5, 2);
            expect_out(1, "tol_accept", k >= 5, 0, 0, 5, 2);
         end else begin
            expect_out(0, "tol_p6_strict", 0, 1, 6, 6, 2);
            expect_out(1, "tol_p6", 0, 1, 1, 6, 2);
         end
         if (k <= 5)      tail(5, 2);
         else if (k == 6) tail(6, 2);
         else             tail(4, 2);
      end

      // Saturation: 300 bad periods alternating 5 and 6.
      do_reset("reset_sat");
      for (int i = 0; i <= 300; i++) begin
         step(1);
         if (i == 0) expect_out(0, "sat_first", 0, 0, 0, 0, 0);
         else        expect_out(0, "sat", 0, 1, (i < 255) ? i : 255, ((i - 1) % 2 == 0) ? 5 : 6, 2);
         tail((i % 2 == 0) ? 5 : 6, 2);
      end

      for (int k = 0; k < 10 && sb_q.size() > 0; k++) step(0);
      if (sb_q.size() != 0) begin
         total += sb_q.size();
         bad   += sb_q.size();
         $display("FAIL drain: %0d checks never reached, required 0", sb_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
